// File: rtl/protection_supervisor.sv
// protection_supervisor: start-up / fault-recovery sequencer for a power converter.
// Runs a fault-free precheck, ramps the duty ceiling, supervises RUN, retries
// after faults with a back-off and latches a lockout when retries run out.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   IDLE       0 | everything off, waiting for start
//   PRECHECK   1 | protection on, converter off, counting fault-free cycles
//   SOFTSTART  2 | converter on, duty ceiling ramping toward DUTY_MAX
//   RUN        3 | full duty ceiling; long fault-free run forgives retries
//   FAULT      4 | one-cycle fault stop, decides retry vs lockout
//   RETRY_WAIT 5 | back-off before the next precheck
//   LOCKOUT    6 | latched off until operator clear_lockout
module protection_supervisor #(
  parameter int unsigned PRECHECK_CYCLES  = 16,
  parameter int unsigned PRECHECK_TIMEOUT = 255,
  parameter logic [15:0] RAMP_STEP        = 16'h0040,
  parameter int unsigned RAMP_DIV         = 4,
  parameter logic [15:0] DUTY_MAX         = 16'hF000,
  parameter int unsigned RETRY_DELAY      = 1000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  fault_in,
  input  logic        shutdown_in,
  input  logic        clear_lockout,
  output logic        prot_enable,
  output logic        conv_enable,
  output logic [15:0] duty_limit,
  output logic [2:0]  retry_count,
  output logic        lockout,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRECHECK   = 3'd1,
    S_SOFTSTART  = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4,
    S_RETRY_WAIT = 3'd5,
    S_LOCKOUT    = 3'd6
  } state_t;

  // One down-counter serves the precheck timeout, the retry back-off and the
  // RUN stability window, since those phases never overlap.
  localparam int unsigned TMAX = (RETRY_DELAY > PRECHECK_TIMEOUT) ? RETRY_DELAY : PRECHECK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PRE_LOAD = TW'(PRECHECK_TIMEOUT - 1);
  localparam logic [TW-1:0] DLY_LOAD = TW'(RETRY_DELAY - 1);
  localparam int GW = $clog2(PRECHECK_CYCLES + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(PRECHECK_CYCLES - 1);
  localparam int KW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [KW-1:0] TICK_LOAD = KW'(RAMP_DIV - 1);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

  state_t        st;
  logic [GW-1:0] good_cnt;
  logic [TW-1:0] timer;
  logic [KW-1:0] tick;
  logic          any_fault;
  logic [16:0]   ramp_sum;
  logic [15:0]   ramp_next;

  // Backflow (bit 4) only pauses the ramp; it never trips the supervisor.
  assign any_fault = (|fault_in[3:0]) | shutdown_in;
  assign ramp_sum  = {1'b0, duty_limit} + {1'b0, RAMP_STEP};
  assign ramp_next = (ramp_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : ramp_sum[15:0];
  assign state     = st;

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      prot_enable <= 1'b0;
      conv_enable <= 1'b0;
      duty_limit  <= 16'h0000;
      retry_count <= 3'd0;
      lockout     <= 1'b0;
      good_cnt    <= '0;
      timer       <= '0;
      tick        <= '0;
    end else if (st == S_LOCKOUT) begin
      // Only the operator acknowledge gets out; start wins nothing here.
      if (clear_lockout) begin
        st          <= S_IDLE;
        lockout     <= 1'b0;
        retry_count <= 3'd0;
      end
    end else if (stop) begin
      st          <= S_IDLE;
      prot_enable <= 1'b0;
      conv_enable <= 1'b0;
      duty_limit  <= 16'h0000;
      retry_count <= 3'd0;
      good_cnt    <= '0;
      timer       <= '0;
      tick        <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            st          <= S_PRECHECK;
            prot_enable <= 1'b1;
            good_cnt    <= '0;
            timer       <= PRE_LOAD;
          end
        end
        S_PRECHECK: begin
          // Reaching the good count wins a tie with the timeout.
          if (!any_fault && good_cnt == GOOD_LAST) begin
            st          <= S_SOFTSTART;
            conv_enable <= 1'b1;
            duty_limit  <= 16'h0000;
            tick        <= TICK_LOAD;
          end else if (timer == '0) begin
            st <= S_FAULT;
          end else begin
            timer    <= timer - 1'b1;
            good_cnt <= any_fault ? '0 : good_cnt + 1'b1;
          end
        end
        S_SOFTSTART: begin
          if (any_fault) begin
            st          <= S_FAULT;
            conv_enable <= 1'b0;
            duty_limit  <= 16'h0000;
          end else if (!fault_in[4]) begin
            if (tick == '0) begin
              tick       <= TICK_LOAD;
              duty_limit <= ramp_next;
              if (ramp_next == DUTY_MAX) begin
                st    <= S_RUN;
                timer <= DLY_LOAD;
              end
            end else begin
              tick <= tick - 1'b1;
            end
          end
        end
        S_RUN: begin
          if (any_fault) begin
            st          <= S_FAULT;
            conv_enable <= 1'b0;
            duty_limit  <= 16'h0000;
          end else if (timer == '0) begin
            retry_count <= 3'd0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_FAULT: begin
          if (retry_count == RETRY_LIMIT) begin
            st          <= S_LOCKOUT;
            lockout     <= 1'b1;
            prot_enable <= 1'b0;
          end else begin
            st          <= S_RETRY_WAIT;
            retry_count <= retry_count + 3'd1;
            timer       <= DLY_LOAD;
          end
        end
        S_RETRY_WAIT: begin
          if (timer == '0) begin
            st       <= S_PRECHECK;
            good_cnt <= '0;
            timer    <= PRE_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          st          <= S_IDLE;
          prot_enable <= 1'b0;
          conv_enable <= 1'b0;
          duty_limit  <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_protection_supervisor.sv
// tb_protection_supervisor: directed scenarios plus a per-cycle reference model.
module tb_protection_supervisor;

  localparam int PC   = 4;
  localparam int PT   = 255;
  localparam int RDIV = 2;
  localparam int RD   = 8;
  localparam int MR   = 2;
  localparam logic [15:0] STEP = 16'h4000;
  localparam logic [15:0] DMAX = 16'hF000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [4:0]  fault_in = 5'b0;
  logic        shutdown_in = 1'b0;
  logic        clear_lockout = 1'b0;
  logic        prot_enable;
  logic        conv_enable;
  logic [15:0] duty_limit;
  logic [2:0]  retry_count;
  logic        lockout;
  logic [2:0]  state;

  protection_supervisor #(
    .PRECHECK_CYCLES(PC), .PRECHECK_TIMEOUT(PT), .RAMP_STEP(STEP), .RAMP_DIV(RDIV),
    .DUTY_MAX(DMAX), .RETRY_DELAY(RD), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fault_in(fault_in),
    .shutdown_in(shutdown_in), .clear_lockout(clear_lockout),
    .prot_enable(prot_enable), .conv_enable(conv_enable), .duty_limit(duty_limit),
    .retry_count(retry_count), .lockout(lockout), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: phase + elapsed-cycle bookkeeping, outputs derived from phase.
  int m_st = 0, m_good = 0, m_age = 0, m_ramp_age = 0, m_steps = 0, m_run_age = 0, m_retry = 0;

  function automatic int m_duty();
    int d;
    d = m_steps * int'(STEP);
    if (m_st == 3) return int'(DMAX);
    if (m_st == 2) return (d >= int'(DMAX)) ? int'(DMAX) : d;
    return 0;
  endfunction

  // Advance the model on every rising edge using the same sampled inputs.
  always @(posedge clk) begin : model
    bit af;
    af = (|fault_in[3:0]) || shutdown_in;
    if (rst) begin
      m_st = 0; m_retry = 0;
    end else if (m_st == 6) begin
      if (clear_lockout) begin m_st = 0; m_retry = 0; end
    end else if (stop) begin
      m_st = 0; m_retry = 0;
    end else begin
      case (m_st)
        0: if (start) begin m_st = 1; m_age = 0; m_good = 0; end
        1: begin
          m_age++;
          m_good = af ? 0 : m_good + 1;
          if (m_good == PC) begin m_st = 2; m_steps = 0; m_ramp_age = 0; end
          else if (m_age == PT) m_st = 4;
        end
        2: begin
          if (af) m_st = 4;
          else if (!fault_in[4]) begin
            m_ramp_age++;
            if (m_ramp_age % RDIV == 0) m_steps++;
            if (m_steps * int'(STEP) >= int'(DMAX)) begin m_st = 3; m_run_age = 0; end
          end
        end
        3: begin
          if (af) m_st = 4;
          else begin
            m_run_age++;
            if (m_run_age >= RD) m_retry = 0;
          end
        end
        4: begin
          if (m_retry == MR) m_st = 6;
          else begin m_retry++; m_st = 5; m_age = 0; end
        end
        5: begin
          m_age++;
          if (m_age == RD) begin m_st = 1; m_age = 0; m_good = 0; end
        end
        default: m_st = 0;
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("m_state", int'(state), m_st);
      chk("m_prot", int'(prot_enable), (m_st >= 1 && m_st <= 5) ? 1 : 0);
      chk("m_conv", int'(conv_enable), (m_st == 2 || m_st == 3) ? 1 : 0);
      chk("m_duty", int'(duty_limit), m_duty());
      chk("m_retry", int'(retry_count), m_retry);
      chk("m_lockout", int'(lockout), (m_st == 6) ? 1 : 0);
    end
  end

  initial begin
    tick(2);
    checking = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("rst_state", int'(state), 0);
    chk("rst_prot", int'(prot_enable), 0);
    chk("rst_duty", int'(duty_limit), 0);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_retry", int'(retry_count), 0);

    // clean start and full ramp
    start = 1'b1; tick(1);
    chk("pre_state", int'(state), 1);
    chk("pre_prot", int'(prot_enable), 1);
    chk("pre_conv", int'(conv_enable), 0);
    start = 1'b0; tick(3);
    chk("pre_last", int'(state), 1);
    tick(1);
    chk("ss_state", int'(state), 2);
    chk("ss_conv", int'(conv_enable), 1);
    chk("ss_duty0", int'(duty_limit), 0);
    tick(2); chk("ramp1", int'(duty_limit), 16'h4000);
    tick(2); chk("ramp2", int'(duty_limit), 16'h8000);
    tick(2); chk("ramp3", int'(duty_limit), 16'hC000);
    chk("ramp3_state", int'(state), 2);
    tick(2); chk("ramp4", int'(duty_limit), 16'hF000);
    chk("run_state", int'(state), 3);

    // stop beats overvoltage in RUN
    stop = 1'b1; fault_in = 5'b00001; tick(1);
    chk("stopov_state", int'(state), 0);
    chk("stopov_retry", int'(retry_count), 0);
    chk("stopov_duty", int'(duty_limit), 0);
    stop = 1'b0; fault_in = 5'b0;

    // start together with stop stays idle
    start = 1'b1; stop = 1'b1; tick(2);
    chk("startstop", int'(state), 0);
    start = 1'b0; stop = 1'b0;

    // backflow pauses the ramp
    start = 1'b1; tick(1); start = 1'b0;
    tick(4); tick(2);
    chk("bf_pre", int'(duty_limit), 16'h4000);
    fault_in = 5'b10000; tick(6);
    chk("bf_hold", int'(duty_limit), 16'h4000);
    chk("bf_state", int'(state), 2);
    fault_in = 5'b0; tick(1);
    chk("bf_rel1", int'(duty_limit), 16'h4000);
    tick(1); chk("bf_rel2", int'(duty_limit), 16'h8000);
    tick(4); chk("bf_run", int'(state), 3);

    // fault in RUN, retry, and stability window clears retry_count
    fault_in = 5'b00001; tick(1);
    chk("runf_state", int'(state), 4);
    chk("runf_duty", int'(duty_limit), 0);
    chk("runf_conv", int'(conv_enable), 0);
    chk("runf_prot", int'(prot_enable), 1);
    fault_in = 5'b0; tick(1);
    chk("rw_state", int'(state), 5);
    chk("rw_retry", int'(retry_count), 1);
    tick(7); chk("rw_end", int'(state), 5);
    tick(1); chk("rw_pre", int'(state), 1);
    tick(4); chk("rw_ss", int'(state), 2);
    tick(8); chk("rw_run", int'(state), 3);
    tick(7); chk("stab_hold", int'(retry_count), 1);
    tick(1); chk("stab_clr", int'(retry_count), 0);
    stop = 1'b1; tick(1); stop = 1'b0;

    // shutdown held: precheck timeout
    shutdown_in = 1'b1; start = 1'b1; tick(1);
    chk("to_pre", int'(state), 1);
    start = 1'b0; tick(254);
    chk("to_last", int'(state), 1);
    tick(1); chk("to_fault", int'(state), 4);
    tick(1); chk("to_rw", int'(state), 5);
    chk("to_retry", int'(retry_count), 1);
    shutdown_in = 1'b0; clear_lockout = 1'b1; tick(1); clear_lockout = 1'b0;
    chk("clr_ignored", int'(state), 5);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("to_idle_retry", int'(retry_count), 0);

    // three overcurrent faults in SOFTSTART -> lockout
    start = 1'b1; tick(1); start = 1'b0;
    tick(4); chk("oc_ss", int'(state), 2);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      fault_in = 5'b00100; tick(1);
      chk("oc_fault", int'(state), 4);
      fault_in = 5'b0; tick(1);
      if (k < 3) begin
        chk("oc_retry", int'(retry_count), k);
        chk("oc_rw", int'(state), 5);
        tick(8); tick(4);
      end
    end
    chk("lo_state", int'(state), 6);
    chk("lo_flag", int'(lockout), 1);
    chk("lo_prot", int'(prot_enable), 0);
    chk("lo_retry", int'(retry_count), 2);
    stop = 1'b1; start = 1'b1; fault_in = 5'b00001; tick(3);
    chk("lo_ignore", int'(state), 6);
    stop = 1'b0; fault_in = 5'b0;
    clear_lockout = 1'b1; tick(1);
    clear_lockout = 1'b0; start = 1'b0;
    chk("clr_state", int'(state), 0);
    chk("clr_lockout", int'(lockout), 0);
    chk("clr_retry", int'(retry_count), 0);
    tick(1); chk("clr_stay", int'(state), 0);

    // reset mid-ramp
    start = 1'b1; tick(1); start = 1'b0;
    tick(4); tick(4);
    chk("mr_duty", int'(duty_limit), 16'h8000);
    rst = 1'b1; tick(1);
    chk("mr_state", int'(state), 0);
    chk("mr_duty0", int'(duty_limit), 0);
    chk("mr_conv", int'(conv_enable), 0);
    chk("mr_prot", int'(prot_enable), 0);
    rst = 1'b0; tick(2);
    chk("mr_idle", int'(state), 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
